// File: rtl/fan_pkg.sv
// fan_pkg: shared mode encodings and level-to-duty table for the fan sequencer
package fan_pkg;
  localparam int LW = 2;
  typedef enum logic [1:0] {MODE_IDLE = 2'd0, MODE_MANUAL = 2'd1, MODE_AUTO = 2'd2} mode_t;
  localparam logic [7:0] LEVEL_DUTY [4] = '{8'd0, 8'd85, 8'd170, 8'd255};
endpackage

// File: rtl/duty_ramp.sv
// duty_ramp: soft-start ramp moving duty one LSB toward target every RAMP_DIV cycles
module duty_ramp #(
  parameter int RAMP_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] target,
  output logic [7:0] duty,
  output logic       ramping
);
  localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  logic [CW-1:0] cnt;
  assign ramping = duty != target;
  // direction is decided at each step, so a target change mid-ramp keeps the counter phase
  always_ff @(posedge clk)
    if (reset_p) begin
      duty <= '0;
      cnt  <= '0;
    end else if (!ramping) cnt <= '0;
    else if (cnt == CW'(RAMP_DIV - 1)) begin
      cnt  <= '0;
      duty <= duty < target ? duty + 8'd1 : duty - 8'd1;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/fan_speed_sequencer.sv
// fan_speed_sequencer: mode/level FSM with AUTO temperature hysteresis feeding a duty ramp
import fan_pkg::*;
module fan_speed_sequencer #(
  parameter int         RAMP_DIV = 100_000,
  parameter logic [7:0] T1       = 8'd24,
  parameter logic [7:0] T2       = 8'd27,
  parameter logic [7:0] T3       = 8'd30,
  parameter logic [7:0] HYST     = 8'd1
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          btn_next,
  input  logic          btn_back,
  input  logic          btn_auto,
  input  logic          timeout,
  input  logic [7:0]    temp,
  input  logic          temp_valid,
  output logic [7:0]    duty,
  output logic [LW-1:0] level,
  output logic [1:0]    mode,
  output logic          run_e,
  output logic          ramping
);
  mode_t         st, st_n;
  logic [LW-1:0] level_n, up, hy, auto_lvl;
  logic          auto_seen, seen_n;
  assign mode  = st;
  assign run_e = duty != 8'd0;
  assign up = {1'b0, temp >= T1} + {1'b0, temp >= T2} + {1'b0, temp >= T3};
  assign hy = {1'b0, temp >= T1 - HYST} + {1'b0, temp >= T2 - HYST} + {1'b0, temp >= T3 - HYST};
  assign auto_lvl = !auto_seen || up > level ? up : (hy < level ? hy : level);
  always_ff @(posedge clk)
    if (reset_p) begin
      st        <= MODE_IDLE;
      level     <= '0;
      auto_seen <= 1'b0;
    end else begin
      st        <= st_n;
      level     <= level_n;
      auto_seen <= seen_n;
    end
  always_comb begin
    st_n    = st;
    level_n = level;
    seen_n  = auto_seen;
    if (timeout) begin
      st_n    = MODE_IDLE;
      level_n = '0;
    end else if (btn_back) begin
      if (st != MODE_IDLE) begin
        st_n    = level <= 2'd1 ? MODE_IDLE : MODE_MANUAL;
        level_n = level <= 2'd1 ? 2'd0 : level - 2'd1;
      end
    end else if (btn_next) begin
      st_n    = MODE_MANUAL;
      level_n = level == 2'd3 ? 2'd1 : level + 2'd1;
    end else if (btn_auto) begin
      st_n    = st == MODE_AUTO ? MODE_MANUAL : MODE_AUTO;
      level_n = level == 2'd0 ? 2'd1 : level;
    end else if (temp_valid && st == MODE_AUTO) begin
      level_n = auto_lvl;
      seen_n  = 1'b1;
    end
    if (st_n != MODE_AUTO) seen_n = 1'b0;
  end
  duty_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
    .clk    (clk),
    .reset_p(reset_p),
    .target (LEVEL_DUTY[level]),
    .duty   (duty),
    .ramping(ramping)
  );
endmodule
